// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage data-access controller
//
// Sits between the EX/MEM and MEM/WB latches. Issues dcache requests,
// holds them until dhit, captures load data, gates MEM/WB advance and
// raises a stall to the hazard unit while an access is outstanding.
// After a HALT retires, no further requests are issued until reset.
//
// Optional feature: define LLSC_EN to add LL/SC atomics backed by a
// link register (valid bit + address). Without it, ll_in/sc_in are
// ignored and LL/SC behave as plain LW/SW.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   dREN_in, dWEN_in   EX/MEM load / store flags
//   addr_in, store_in  EX/MEM data address and store data
//   halt_in            EX/MEM halt reached MEM
//   ll_in, sc_in       EX/MEM LL / SC opcodes (LLSC_EN only)
//   ext_stall          downstream stall, MEM/WB must not advance
//   dhit, dmemload     dcache completion and load data
//   dmemREN, dmemWEN   dcache read / write request
//   dmemaddr, dmemstore dcache address / write data
//   load_out           data to MEM/WB
//   memwb_wen          MEM/WB write enable
//   memwb_flush        MEM/WB flush (bubble)
//   mem_stall          freeze IF..EX/MEM
//   halted             sticky: halt retired into MEM/WB

module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] store_in,
  input  logic              halt_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic              ext_stall,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmemstore,
  output logic [ADDR_W-1:0] load_out,
  output logic              memwb_wen,
  output logic              memwb_flush,
  output logic              mem_stall,
  output logic              halted
);

  typedef logic [ADDR_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_q, state_d;
  word_t  load_q, load_d;

  // Request snapshot taken in IDLE so ACCESS drives a stable request
  // even if the upstream latch were to change underneath it.
  word_t  req_addr_q, req_addr_d;
  word_t  req_data_q, req_data_d;
  logic   req_ren_q, req_ren_d;
  logic   req_wen_q, req_wen_d;
  logic   req_ll_q, req_ll_d;
  logic   req_sc_q, req_sc_d;

  // Decoded current EX/MEM request. Both flags set is illegal and is
  // treated as a store.
  logic cur_ren, cur_wen, cur_acc;
  logic cur_ll, cur_sc, sc_fail;

  // Combinational versions of the outputs, gated by nRST below.
  logic  ren_c, wen_c, memwb_wen_c, flush_c, stall_c;
  word_t addr_c, store_c;

  // Completion event for the link-register tracker.
  logic  done_c, done_ll_c, done_st_c;
  word_t done_addr_c;

  assign cur_ren = dREN_in & ~dWEN_in;
  assign cur_wen = dWEN_in;
  assign cur_acc = dREN_in | dWEN_in;

`ifdef LLSC_EN
  logic  link_valid_q, link_valid_d;
  word_t link_addr_q, link_addr_d;

  assign cur_ll  = ll_in & cur_ren;
  assign cur_sc  = sc_in & cur_wen;
  // An SC without a matching live link must not touch the cache.
  assign sc_fail = cur_sc & ~(link_valid_q & (link_addr_q == addr_in));

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (done_c) begin
      if (done_ll_c) begin
        link_valid_d = 1'b1;
        link_addr_d  = done_addr_c;
      end else if (done_st_c && (done_addr_c == link_addr_q)) begin
        link_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  logic unused_llsc;

  assign cur_ll      = 1'b0;
  assign cur_sc      = 1'b0;
  assign sc_fail     = 1'b0;
  assign unused_llsc = ^{ll_in, sc_in, done_c, done_ll_c, done_st_c, done_addr_c};
`endif

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_ren_d   = req_ren_q;
    req_wen_d   = req_wen_q;
    req_ll_d    = req_ll_q;
    req_sc_d    = req_sc_q;
    ren_c       = 1'b0;
    wen_c       = 1'b0;
    addr_c      = '0;
    store_c     = '0;
    memwb_wen_c = 1'b0;
    flush_c     = 1'b0;
    stall_c     = 1'b0;
    done_c      = 1'b0;
    done_ll_c   = 1'b0;
    done_st_c   = 1'b0;
    done_addr_c = addr_in;

    unique case (state_q)
      IDLE: begin
        req_addr_d = addr_in;
        req_data_d = store_in;
        req_ren_d  = cur_ren;
        req_wen_d  = cur_wen;
        req_ll_d   = cur_ll;
        req_sc_d   = cur_sc;
        if (cur_acc) begin
          if (sc_fail) begin
            // Failed SC retires immediately with result 0.
            load_d      = '0;
            memwb_wen_c = ~ext_stall;
            state_d     = ext_stall ? HOLD : IDLE;
          end else begin
            ren_c   = cur_ren;
            wen_c   = cur_wen;
            addr_c  = addr_in;
            store_c = store_in;
            if (dhit) begin
              load_d      = cur_sc ? word_t'(1) : dmemload;
              memwb_wen_c = ~ext_stall;
              state_d     = ext_stall ? HOLD : IDLE;
              done_c      = 1'b1;
              done_ll_c   = cur_ll;
              done_st_c   = cur_wen;
              done_addr_c = addr_in;
            end else begin
              stall_c = 1'b1;
              state_d = ACCESS;
            end
          end
        end else if (halt_in && !ext_stall) begin
          memwb_wen_c = 1'b1;
          state_d     = HALTED;
        end else begin
          memwb_wen_c = ~ext_stall;
        end
      end

      ACCESS: begin
        ren_c   = req_ren_q;
        wen_c   = req_wen_q;
        addr_c  = req_addr_q;
        store_c = req_data_q;
        stall_c = 1'b1;
        if (dhit) begin
          load_d      = req_sc_q ? word_t'(1) : dmemload;
          done_c      = 1'b1;
          done_ll_c   = req_ll_q;
          done_st_c   = req_wen_q;
          done_addr_c = req_addr_q;
          if (!ext_stall) begin
            memwb_wen_c = 1'b1;
            stall_c     = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // Access already done; wait for downstream without re-requesting.
        if (ext_stall) begin
          stall_c = 1'b1;
        end else begin
          memwb_wen_c = 1'b1;
          state_d     = IDLE;
        end
      end

      HALTED: begin
        flush_c     = 1'b1;
        memwb_wen_c = 1'b1;
        stall_c     = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      load_q     <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_ren_q  <= 1'b0;
      req_wen_q  <= 1'b0;
      req_ll_q   <= 1'b0;
      req_sc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_ren_q  <= req_ren_d;
      req_wen_q  <= req_wen_d;
      req_ll_q   <= req_ll_d;
      req_sc_q   <= req_sc_d;
    end
  end

  // Outputs drop immediately while reset is held, even though the IDLE
  // decode is combinational from the EX/MEM inputs.
  assign dmemREN     = nRST & ren_c;
  assign dmemWEN     = nRST & wen_c;
  assign dmemaddr    = nRST ? addr_c : '0;
  assign dmemstore   = nRST ? store_c : '0;
  assign memwb_wen   = nRST & memwb_wen_c;
  assign memwb_flush = nRST & flush_c;
  assign mem_stall   = nRST & stall_c;
  assign halted      = nRST & (state_q == HALTED);
  assign load_out    = load_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN_in = 1'b0, dWEN_in = 1'b0, halt_in = 1'b0;
  logic        ll_in = 1'b0, sc_in = 1'b0, ext_stall = 1'b0, dhit = 1'b0;
  logic [31:0] addr_in = '0, store_in = '0, dmemload = '0;
  logic        dmemREN, dmemWEN, memwb_wen, memwb_flush, mem_stall, halted;
  logic [31:0] dmemaddr, dmemstore, load_out;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .addr_in(addr_in), .store_in(store_in),
    .halt_in(halt_in), .ll_in(ll_in), .sc_in(sc_in),
    .ext_stall(ext_stall), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_out(load_out), .memwb_wen(memwb_wen),
    .memwb_flush(memwb_flush), .mem_stall(mem_stall), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: a completed access (dhit with a live request) must show
  // the expected holding-register value on the following cycle.
  always @(negedge CLK) begin
    if (done_prev) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else check("sb_load_out", load_out, exp_q.pop_front());
    end
    done_prev = nRST & dhit & (dmemREN | dmemWEN);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
    ll_in = 1'b0; sc_in = 1'b0; dhit = 1'b0; ext_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt, ren_cnt, wen_cnt, addr_ok;

    // Reset: outputs low even with a request presented.
    dREN_in = 1'b1; addr_in = 32'h40;
    @(negedge CLK);
    check("rst_ren", {31'd0, dmemREN}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_wen", {31'd0, memwb_wen}, 32'd0);
    check("rst_flush", {31'd0, memwb_flush}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_load", load_out, 32'd0);
    step();
    idle_in();
    nRST = 1'b1;
    step();

    // Load 0x100, dhit after 3 waiting cycles.
    dREN_in = 1'b1; addr_in = 32'h100; dmemload = 32'hDEADBEEF;
    stall_cnt = 0; ren_cnt = 0; wen_cnt = 0; addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      dhit = (c == 3);
      if (c == 3) exp_q.push_back(32'hDEADBEEF);
      @(negedge CLK);
      stall_cnt += int'(mem_stall);
      ren_cnt   += int'(dmemREN);
      wen_cnt   += int'(memwb_wen);
      if (dmemaddr !== 32'h100) addr_ok = 0;
      step();
    end
    idle_in();
    check("ld_stall_cycles", stall_cnt, 3);
    check("ld_ren_cycles", ren_cnt, 4);
    check("ld_wen_pulses", wen_cnt, 1);
    check("ld_addr_stable", addr_ok, 1);
    @(negedge CLK);
    check("ld_req_dropped", {31'd0, dmemREN}, 32'd0);
    step();

    // Store with dhit in the same cycle.
    dWEN_in = 1'b1; addr_in = 32'h200; store_in = 32'h12345678;
    dhit = 1'b1; dmemload = 32'h0BADF00D;
    exp_q.push_back(32'h0BADF00D);
    @(negedge CLK);
    check("st_wen", {31'd0, dmemWEN}, 32'd1);
    check("st_ren", {31'd0, dmemREN}, 32'd0);
    check("st_addr", dmemaddr, 32'h200);
    check("st_data", dmemstore, 32'h12345678);
    check("st_stall", {31'd0, mem_stall}, 32'd0);
    check("st_memwb_wen", {31'd0, memwb_wen}, 32'd1);
    step();
    idle_in();
    @(negedge CLK);
    check("st_wen_one_cycle", {31'd0, dmemWEN}, 32'd0);
    step();

    // Illegal REN+WEN is a store.
    dREN_in = 1'b1; dWEN_in = 1'b1; addr_in = 32'h204; dhit = 1'b1; dmemload = 32'h0;
    exp_q.push_back(32'h0);
    @(negedge CLK);
    check("both_ren", {31'd0, dmemREN}, 32'd0);
    check("both_wen", {31'd0, dmemWEN}, 32'd1);
    step();
    idle_in();

    // Load hit under ext_stall, held for two more cycles.
    dREN_in = 1'b1; addr_in = 32'h104; dhit = 1'b1; ext_stall = 1'b1; dmemload = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    @(negedge CLK);
    check("hold_hit_wen", {31'd0, memwb_wen}, 32'd0);
    step();
    dhit = 1'b0; dmemload = 32'h11111111;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("hold_no_req", {31'd0, dmemREN}, 32'd0);
      check("hold_stall", {31'd0, mem_stall}, 32'd1);
      check("hold_wen", {31'd0, memwb_wen}, 32'd0);
      check("hold_load", load_out, 32'hCAFEF00D);
      step();
    end
    ext_stall = 1'b0;
    @(negedge CLK);
    check("hold_release_wen", {31'd0, memwb_wen}, 32'd1);
    check("hold_release_stall", {31'd0, mem_stall}, 32'd0);
    step();
    idle_in();

    // Miss, then hit under ext_stall from ACCESS.
    dREN_in = 1'b1; addr_in = 32'h108; dmemload = 32'h55AA55AA;
    @(negedge CLK);
    check("acc_miss_stall", {31'd0, mem_stall}, 32'd1);
    step();
    dhit = 1'b1; ext_stall = 1'b1;
    exp_q.push_back(32'h55AA55AA);
    @(negedge CLK);
    check("acc_hit_stalled_wen", {31'd0, memwb_wen}, 32'd0);
    check("acc_hit_stalled_stall", {31'd0, mem_stall}, 32'd1);
    step();
    dhit = 1'b0; ext_stall = 1'b0;
    @(negedge CLK);
    check("acc_hold_ren", {31'd0, dmemREN}, 32'd0);
    check("acc_hold_wen", {31'd0, memwb_wen}, 32'd1);
    step();
    idle_in();

    // Halt after a completed load.
    dREN_in = 1'b1; addr_in = 32'h10C; dhit = 1'b1; dmemload = 32'h01020304;
    exp_q.push_back(32'h01020304);
    step();
    idle_in();
    halt_in = 1'b1;
    @(negedge CLK);
    check("halt_wen", {31'd0, memwb_wen}, 32'd1);
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    step();
    halt_in = 1'b0; dREN_in = 1'b1; addr_in = 32'h400;
    @(negedge CLK);
    check("halted", {31'd0, halted}, 32'd1);
    check("halted_ren", {31'd0, dmemREN}, 32'd0);
    check("halted_flush", {31'd0, memwb_flush}, 32'd1);
    check("halted_memwb_wen", {31'd0, memwb_wen}, 32'd1);
    check("halted_stall", {31'd0, mem_stall}, 32'd1);
    step();
    dREN_in = 1'b0; dWEN_in = 1'b1; dhit = 1'b1;
    @(negedge CLK);
    check("halted_wen", {31'd0, dmemWEN}, 32'd0);
    check("halted_sticky", {31'd0, halted}, 32'd1);
    step();
    idle_in();

    // Reset pulse mid-ACCESS.
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    dREN_in = 1'b1; addr_in = 32'h500;
    step();
    @(negedge CLK);
    check("mid_acc_ren", {31'd0, dmemREN}, 32'd1);
    check("mid_acc_halted", {31'd0, halted}, 32'd0);
    #1 nRST = 1'b0;
    #1;
    check("async_rst_ren", {31'd0, dmemREN}, 32'd0);
    check("async_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("async_rst_addr", dmemaddr, 32'd0);
    step();
    idle_in();
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_idle_wen", {31'd0, memwb_wen}, 32'd1);
    check("post_rst_stall", {31'd0, mem_stall}, 32'd0);
    step();

`ifdef LLSC_EN
    // LL then SC to the same address succeeds.
    dREN_in = 1'b1; ll_in = 1'b1; addr_in = 32'h300; dhit = 1'b1; dmemload = 32'h77;
    exp_q.push_back(32'h77);
    step();
    idle_in();
    dWEN_in = 1'b1; sc_in = 1'b1; addr_in = 32'h300; store_in = 32'hAB; dhit = 1'b1;
    exp_q.push_back(32'd1);
    @(negedge CLK);
    check("sc_ok_wen", {31'd0, dmemWEN}, 32'd1);
    step();
    idle_in();
    // SW to the linked address, then SC fails without a request.
    dWEN_in = 1'b1; addr_in = 32'h300; dhit = 1'b1; dmemload = 32'h99;
    exp_q.push_back(32'h99);
    step();
    idle_in();
    dWEN_in = 1'b1; sc_in = 1'b1; addr_in = 32'h300;
    @(negedge CLK);
    check("sc_fail_wen", {31'd0, dmemWEN}, 32'd0);
    check("sc_fail_stall", {31'd0, mem_stall}, 32'd0);
    check("sc_fail_memwb", {31'd0, memwb_wen}, 32'd1);
    step();
    idle_in();
    @(negedge CLK);
    check("sc_fail_load", load_out, 32'd0);
    step();
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
